instruction_memory_responder: RTL

//   Memory-side responder for the instruction-cache refill interface. Accepts cacheline

---
 rtl/instruction_memory_responder.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/instruction_memory_responder.sv
// ============================================================================
// instruction_memory_responder
//
// Memory-side responder for the instruction-cache refill interface.
// Several instruction caches raise cacheline read requests. A round-robin
// arbiter picks one of them and forwards it to a single backing memory port
// that uses a req/gnt handshake and returns read data in request order.
// Each granted requestor ID is kept in a small in-flight FIFO. When read data
// comes back, the ID at the head of the FIFO selects which cache receives a
// one-cycle valid pulse. The cacheline data bus is shared by all caches.
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous reset, active low
//   ic_req_i      per-cache refill request; held with its address until ready
//   ic_ready_o    per-cache accept strobe (one-hot or zero), combinational
//   ic_addr_i     per-cache cacheline address, cache i at [i*AddrW +: AddrW]
//   ic_valid_o    per-cache response pulse (one-hot or zero), registered
//   ic_data_o     response cacheline, shared; holds its value between pulses
//   mem_req_o     backing memory read request
//   mem_gnt_i     backing memory accepts the current request
//   mem_addr_o    backing memory cacheline address
//   mem_rvalid_i  read data valid, returned in request order
//   mem_rdata_i   read data
// ============================================================================
module instruction_memory_responder #(
    parameter int NumRequestors    = 4,
    parameter int PcWidth          = 32,
    parameter int EncInstWidth     = 32,
    parameter int CachelineIdxBits = 1,
    parameter int MaxOutstanding   = 4,
    localparam int AddrW = PcWidth - CachelineIdxBits,
    localparam int LineW = (1 << CachelineIdxBits) * EncInstWidth,
    localparam int IdW   = (NumRequestors > 1) ? $clog2(NumRequestors) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumRequestors-1:0]       ic_req_i,
    output logic [NumRequestors-1:0]       ic_ready_o,
    input  logic [NumRequestors*AddrW-1:0] ic_addr_i,
    output logic [NumRequestors-1:0]       ic_valid_o,
    output logic [LineW-1:0]               ic_data_o,
    output logic                           mem_req_o,
    input  logic                           mem_gnt_i,
    output logic [AddrW-1:0]               mem_addr_o,
    input  logic                           mem_rvalid_i,
    input  logic [LineW-1:0]               mem_rdata_i
);

    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------

    // Round-robin pick: the first requester after 'last', wrapping around.
    // The loop runs from the farthest offset to the nearest so that the
    // nearest requester is the one left in 'pick'. Returns 'last' when no
    // request is raised; callers gate the result with the request-present
    // flag.
    function automatic logic [IdW-1:0] rr_pick(
        input logic [IdW-1:0]           last,
        input logic [NumRequestors-1:0] req
    );
        logic [IdW-1:0] pick;
        logic [IdW-1:0] idx_l;
        int             idx;
        pick = last;
        for (int k = NumRequestors; k >= 1; k--) begin
            idx   = (int'(last) + k) % NumRequestors;
            idx_l = IdW'(idx);
            if (req[idx_l]) begin
                pick = idx_l;
            end
        end
        return pick;
    endfunction

    function automatic logic [NumRequestors-1:0] id_onehot(input logic [IdW-1:0] id);
        logic [NumRequestors-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

    // FIFO pointers wrap at MaxOutstanding, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(MaxOutstanding - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // ------------------------------------------------------------------------
    // Stage p0: arbitration and memory request (combinational)
    // ------------------------------------------------------------------------
    logic [AddrW-1:0]         req_addr_p0 [NumRequestors];
    logic                     any_req_p0;
    logic [IdW-1:0]           cand_id_p0;
    logic                     handshake_p0;

    logic [IdW-1:0]           rr_q;
    logic [IdW-1:0]           id_fifo [MaxOutstanding];
    logic [PtrW-1:0]          wr_ptr_q;
    logic [PtrW-1:0]          rd_ptr_q;
    logic [CntW-1:0]          count_q;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [IdW-1:0]           head_id;
    logic                     vld_p0;

    logic [NumRequestors-1:0] rsp_onehot_p1;
    logic [LineW-1:0]         rsp_data_p1;

    for (genvar g = 0; g < NumRequestors; g++) begin : g_addr_unpack
        assign req_addr_p0[g] = ic_addr_i[g*AddrW +: AddrW];
    end

    assign fifo_full  = (count_q == CntW'(MaxOutstanding));
    assign fifo_empty = (count_q == '0);
    assign any_req_p0 = |ic_req_i;
    assign cand_id_p0 = rr_pick(rr_q, ic_req_i);

    // A full FIFO blocks issue even when a response pops an entry in the same
    // cycle; the freed slot becomes usable on the following cycle.
    assign mem_req_o    = any_req_p0 && !fifo_full;
    assign mem_addr_o   = req_addr_p0[cand_id_p0];
    assign handshake_p0 = mem_req_o && mem_gnt_i;

    always_comb begin
        ic_ready_o = '0;
        if (handshake_p0) begin
            ic_ready_o = id_onehot(cand_id_p0);
        end
    end

    // Round-robin pointer: remembers the last granted requester.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= IdW'(NumRequestors - 1);
        end else if (handshake_p0) begin
            rr_q <= cand_id_p0;
        end
    end

    // ------------------------------------------------------------------------
    // In-flight ID FIFO (push on grant, pop on read data)
    // ------------------------------------------------------------------------
    assign head_id = id_fifo[rd_ptr_q];
    // A response with no outstanding entry is a system error. It is flagged
    // by the checker below and ignored here so that occupancy cannot wrap.
    assign vld_p0  = mem_rvalid_i && !fifo_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (handshake_p0) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (vld_p0) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({handshake_p0, vld_p0})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset: occupancy alone defines which entries
    // are live.
    always_ff @(posedge clk_i) begin
        if (handshake_p0) begin
            id_fifo[wr_ptr_q] <= cand_id_p0;
        end
    end

    // ------------------------------------------------------------------------
    // Stage p1: registered response towards the caches
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_onehot_p1 <= '0;
            rsp_data_p1   <= '0;
        end else begin
            rsp_onehot_p1 <= vld_p0 ? id_onehot(head_id) : '0;
            if (mem_rvalid_i) begin
                rsp_data_p1 <= mem_rdata_i;
            end
        end
    end

    assign ic_valid_o = rsp_onehot_p1;
    assign ic_data_o  = rsp_data_p1;

`ifndef SYNTHESIS
    // ------------------------------------------------------------------------
    // Protocol checks (simulation only)
    // ------------------------------------------------------------------------
    // hold_q[i] marks a cache that requested last cycle without being
    // accepted; such a cache must keep its request and address unchanged.
    logic [NumRequestors-1:0] hold_q;
    logic [AddrW-1:0]         hold_addr_q [NumRequestors];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
        end else begin
            hold_q <= ic_req_i & ~ic_ready_o;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumRequestors; i++) begin
            hold_addr_q[i] <= req_addr_p0[i];
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(mem_rvalid_i && fifo_empty))
                else $fatal(1, "mem_rvalid_i with no outstanding request");
            for (int i = 0; i < NumRequestors; i++) begin
                assert (!(hold_q[i] && (!ic_req_i[i] || (req_addr_p0[i] != hold_addr_q[i]))))
                    else $error("cache %0d dropped request or changed address before ready", i);
            end
            assert ($onehot0(ic_valid_o))
                else $error("ic_valid_o has more than one bit set");
        end
    end
`endif

endmodule
